// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the 16-bit five-stage pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  typedef logic [3:0] reg_t;

  // Register code meaning "no destination"; also the pipeline-register reset value.
  localparam reg_t REG_NONE = 4'b1111;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DMEM = 1'b1
  } state_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
    logic controlwb;
    reg_t wreg;
  } ctl_t;

  // Field values loaded into a pipeline register when it is flushed or bubbled.
  localparam ctl_t CTL_NOP = '{memread: 1'b0, memwrite: 1'b0, controlwb: 1'b0, wreg: REG_NONE};

  function automatic logic is_nop(input ctl_t c);
    return c == CTL_NOP;
  endfunction

  function automatic logic reg_hit(input reg_t src, input logic used, input reg_t dst);
    return used && (dst != REG_NONE) && (src == dst);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// ============================================================================
//  Module      : hazard_detect
//  Description : Load-use detection: a load in EX writes a register read in ID.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_detect
  import pipe_pkg::*;
(
  input  logic [3:0] i_id_rs,
  input  logic       i_id_rs_used,
  input  logic [3:0] i_id_rt,
  input  logic       i_id_rt_used,
  input  logic       i_idex_memread,
  input  logic [3:0] i_idex_wreg,
  output logic       o_load_use
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit   = reg_hit(i_id_rs, i_id_rs_used, i_idex_wreg);
  assign w_rt_hit   = reg_hit(i_id_rt, i_id_rt_used, i_idex_wreg);
  assign o_load_use = i_idex_memread & (w_rs_hit | w_rt_hit);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall/flush controller: load-use, shared-bus, branch, DMEM wait.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int WAIT_W      = 8,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       i_id_rs,
  input  logic             i_id_rs_used,
  input  logic [3:0]       i_id_rt,
  input  logic             i_id_rt_used,
  input  logic             i_idex_memread,
  input  logic [3:0]       i_idex_wreg,
  input  logic             i_branch_taken,
  input  logic             i_exmem_mem_en,
  input  logic             i_exmem_shared,
  input  logic             i_mem_ready,
  output logic             o_pc_hold,
  output logic             o_ifid_hold,
  output logic             o_ifid_flush,
  output logic             o_idex_hold,
  output logic             o_idex_flush,
  output logic             o_exmem_hold,
  output logic             o_memwb_bubble,
  output logic             o_if_bus_grant,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt
);

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_mem_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_lu;
  logic w_sh;
  logic w_wait_hit;
  logic w_done;
  logic w_pc_hold;
  logic w_ifid_hold;
  logic w_ifid_flush;
  logic w_idex_hold;
  logic w_idex_flush;
  logic w_exmem_hold;
  logic w_memwb_bubble;
  logic w_if_bus_grant;

  hazard_detect u_hazard_detect (
    .i_id_rs        (i_id_rs),
    .i_id_rs_used   (i_id_rs_used),
    .i_id_rt        (i_id_rt),
    .i_id_rt_used   (i_id_rt_used),
    .i_idex_memread (i_idex_memread),
    .i_idex_wreg    (i_idex_wreg),
    .o_load_use     (w_lu)
  );

  assign w_sh       = i_exmem_mem_en & i_exmem_shared;
  assign w_wait_hit = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT));

  // In DMEM the access is already outstanding, so only ready or timeout release it.
  assign w_done = (r_state == ST_DMEM) ? (i_mem_ready | w_wait_hit)
                                       : (~i_exmem_mem_en | i_mem_ready);

  always_comb begin
    w_pc_hold      = 1'b0;
    w_ifid_hold    = 1'b0;
    w_ifid_flush   = 1'b0;
    w_idex_hold    = 1'b0;
    w_idex_flush   = 1'b0;
    w_exmem_hold   = 1'b0;
    w_memwb_bubble = 1'b0;
    w_if_bus_grant = 1'b1;
    if (rst) begin
      w_pc_hold      = 1'b1;
      w_ifid_flush   = 1'b1;
      w_idex_flush   = 1'b1;
      w_memwb_bubble = 1'b1;
    end else if (!w_done) begin
      w_pc_hold      = 1'b1;
      w_ifid_hold    = 1'b1;
      w_idex_hold    = 1'b1;
      w_exmem_hold   = 1'b1;
      w_memwb_bubble = 1'b1;
      w_if_bus_grant = ~i_exmem_shared;
    end else begin
      if (w_sh) begin
        w_if_bus_grant = 1'b0;
        w_ifid_flush   = 1'b1;
        w_pc_hold      = ~i_branch_taken;
      end
      // A load-use stall keeps the ID instruction in place, so it overrides any flush.
      if (w_lu) begin
        w_pc_hold    = 1'b1;
        w_ifid_hold  = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b1;
      end else if (i_branch_taken) begin
        w_ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      if (w_pc_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      case (r_state)
        ST_RUN: begin
          if (i_exmem_mem_en && !i_mem_ready) begin
            r_state    <= ST_DMEM;
            r_wait_cnt <= WAIT_W'(1);
          end
        end
        ST_DMEM: begin
          if (w_done) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            if (!i_mem_ready) begin
              r_mem_timeout <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign o_pc_hold      = w_pc_hold;
  assign o_ifid_hold    = w_ifid_hold;
  assign o_ifid_flush   = w_ifid_flush;
  assign o_idex_hold    = w_idex_hold;
  assign o_idex_flush   = w_idex_flush;
  assign o_exmem_hold   = w_exmem_hold;
  assign o_memwb_bubble = w_memwb_bubble;
  assign o_if_bus_grant = w_if_bus_grant;
  assign o_mem_timeout  = r_mem_timeout;
  assign o_stall_cnt    = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  id_rs, id_rt, idex_wreg;
  logic        id_rs_used, id_rt_used, idex_memread;
  logic        branch_taken, exmem_mem_en, exmem_shared, mem_ready;
  logic        pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush;
  logic        exmem_hold, memwb_bubble, if_bus_grant, mem_timeout;
  logic [15:0] stall_cnt;
  logic [7:0]  ctl;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_stall = 0;
  logic        exp_to    = 1'b0;

  // {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_bubble, if_bus_grant}
  localparam logic [7:0] C_RST    = 8'b1010_1011;
  localparam logic [7:0] C_IDLE   = 8'b0000_0001;
  localparam logic [7:0] C_LU     = 8'b1100_1001;
  localparam logic [7:0] C_LU_SH  = 8'b1100_1000;
  localparam logic [7:0] C_SH     = 8'b1010_0000;
  localparam logic [7:0] C_SH_BR  = 8'b0010_0000;
  localparam logic [7:0] C_BR     = 8'b0010_0001;
  localparam logic [7:0] C_FRZ_SH = 8'b1101_0110;
  localparam logic [7:0] C_FRZ    = 8'b1101_0111;

  pipe_hazard_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .i_id_rs        (id_rs),
    .i_id_rs_used   (id_rs_used),
    .i_id_rt        (id_rt),
    .i_id_rt_used   (id_rt_used),
    .i_idex_memread (idex_memread),
    .i_idex_wreg    (idex_wreg),
    .i_branch_taken (branch_taken),
    .i_exmem_mem_en (exmem_mem_en),
    .i_exmem_shared (exmem_shared),
    .i_mem_ready    (mem_ready),
    .o_pc_hold      (pc_hold),
    .o_ifid_hold    (ifid_hold),
    .o_ifid_flush   (ifid_flush),
    .o_idex_hold    (idex_hold),
    .o_idex_flush   (idex_flush),
    .o_exmem_hold   (exmem_hold),
    .o_memwb_bubble (memwb_bubble),
    .o_if_bus_grant (if_bus_grant),
    .o_mem_timeout  (mem_timeout),
    .o_stall_cnt    (stall_cnt)
  );

  assign ctl = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush,
                exmem_hold, memwb_bubble, if_bus_grant};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one cycle mid-period, then advances past the next rising edge.
  task automatic cyc(input string tag, input logic [7:0] exp_ctl);
    #3;
    chk({tag, ".ctl"}, {24'd0, ctl}, {24'd0, exp_ctl});
    chk({tag, ".stall"}, {16'd0, stall_cnt}, exp_stall);
    chk({tag, ".tout"}, {31'd0, mem_timeout}, {31'd0, exp_to});
    @(posedge clk);
    if (rst) exp_stall = 0;
    else if (exp_ctl[7]) exp_stall++;
    #1;
  endtask

  task automatic idle();
    id_rs = 4'd0; id_rs_used = 1'b0; id_rt = 4'd0; id_rt_used = 1'b0;
    idex_memread = 1'b0; idex_wreg = 4'b1111; branch_taken = 1'b0;
    exmem_mem_en = 1'b0; exmem_shared = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [3:0] r);
    idex_memread = 1'b1; idex_wreg = r; id_rs = r; id_rs_used = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    set_lu(4'd3);
    #1;
    cyc("rst0", C_RST);
    cyc("rst1", C_RST);
    rst = 1'b0;
    cyc("first_run_lu", C_LU);

    idle();
    cyc("lu_release", C_IDLE);
    set_lu(4'd3); id_rs_used = 1'b0;
    cyc("lu_rs_unused", C_IDLE);
    set_lu(4'b1111);
    cyc("lu_reg_none", C_IDLE);
    idle(); idex_memread = 1'b1; idex_wreg = 4'd5; id_rt = 4'd5; id_rt_used = 1'b1;
    cyc("lu_rt", C_LU);
    idex_memread = 1'b0;
    cyc("no_load", C_IDLE);

    idle(); exmem_mem_en = 1'b1; exmem_shared = 1'b1; mem_ready = 1'b1;
    cyc("sh", C_SH);
    branch_taken = 1'b1;
    cyc("sh_branch", C_SH_BR);
    idle(); branch_taken = 1'b1;
    cyc("branch", C_BR);
    set_lu(4'd7);
    cyc("lu_over_branch", C_LU);
    idle(); branch_taken = 1'b1;
    cyc("branch_after_lu", C_BR);
    idle(); set_lu(4'd2); exmem_mem_en = 1'b1; exmem_shared = 1'b1; mem_ready = 1'b1;
    cyc("lu_and_sh", C_LU_SH);

    idle(); exmem_mem_en = 1'b1; exmem_shared = 1'b1;
    cyc("wait_sh0", C_FRZ_SH);
    cyc("wait_sh1", C_FRZ_SH);
    cyc("wait_sh2", C_FRZ_SH);
    mem_ready = 1'b1;
    cyc("wait_sh_exit", C_SH);
    idle();
    cyc("wait_sh_after", C_IDLE);

    exmem_mem_en = 1'b1;
    set_lu(4'd9);
    cyc("wait_ns_lu_masked", C_FRZ);
    idle(); exmem_mem_en = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1;
    cyc("wait_ns_exit_br", C_BR);

    idle(); exmem_mem_en = 1'b1;
    for (int i = 0; i < 255; i++) cyc("tmo_wait", C_FRZ);
    cyc("tmo_exit", C_IDLE);
    exp_to = 1'b1;
    cyc("tmo_sticky0", C_FRZ);
    mem_ready = 1'b1;
    cyc("tmo_rewait_exit", C_IDLE);
    idle();
    cyc("tmo_sticky1", C_IDLE);

    rst = 1'b1;
    cyc("rst_again", C_RST);
    exp_to = 1'b0;
    rst = 1'b0;
    cyc("post_rst", C_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
